operand_entry: RTL and testbench

- Front-end input unit for the 8-bit datapath on the board.
- Takes the two raw board push-buttons, synchronises and debounces them, and lets the user key in two 8-bit operands one after the other.
- Presents the operand pair to the downstream arithmetic core with a valid/ready handshake.
- Drives a 6-bit LED preview of the operand currently being edited. It is the input-side counterpart of the result-to-LED output path.

---
 rtl/operand_entry_pkg.sv | 22 ++
 rtl/operand_entry_button_debouncer.sv | 58 +++++
 rtl/operand_entry.sv | 108 ++++++++++
 tb/tb_operand_entry.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/operand_entry_pkg.sv
// Shared types and constants for the operand entry front end.
package operand_entry_pkg;

  // Entry phase, also driven out on the phase port.
  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    PRESENT = 2'd2
  } phase_e;

  // Board buttons are active-low.
  localparam logic BTN_PRESSED  = 1'b0;
  localparam logic BTN_RELEASED = 1'b1;

  // Bit positions within the buttons bus.
  localparam int unsigned BTN_INC  = 0;
  localparam int unsigned BTN_ADV  = 1;
  localparam int unsigned NUM_BTNS = 2;

  localparam int unsigned PREVIEW_W = 6;

endpackage

// File: rtl/operand_entry_button_debouncer.sv
// Synchronises and debounces one active-low button; emits a one-cycle press pulse.
module button_debouncer
  import operand_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Count consecutive disagreeing cycles; flip the stable level once enough have passed.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        pulse_d  = (sync2_q == BTN_PRESSED);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, stable level, counter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= BTN_RELEASED;
      sync2_q  <= BTN_RELEASED;
      stable_q <= BTN_RELEASED;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/operand_entry.sv
// Button-driven entry of two operands, offered downstream with valid/ready.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_BTNS-1:0]  buttons,
  output logic [WIDTH-1:0]     operand_a,
  output logic [WIDTH-1:0]     operand_b,
  output logic                 operands_valid,
  input  logic                 operands_ready,
  output logic [1:0]           phase,
  output logic [PREVIEW_W-1:0] preview
);

  logic inc_pulse;
  logic adv_pulse;

  phase_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 valid_q, valid_d;
  logic [PREVIEW_W-1:0] preview_q, preview_d;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (buttons[BTN_INC]),
    .press_pulse (inc_pulse)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adv_db (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (buttons[BTN_ADV]),
    .press_pulse (adv_pulse)
  );

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next phase: a lone advance moves on; the handshake returns to operand A.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ENTER_A: if (adv_pulse && !inc_pulse) state_d = ENTER_B;
      ENTER_B: if (adv_pulse && !inc_pulse) state_d = PRESENT;
      PRESENT: if (operands_ready)          state_d = ENTER_A;
      default:                              state_d = ENTER_A;
    endcase
  end

  // Operand edits and next output values; both pulses together clear the operand.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    valid_d   = 1'b0;
    preview_d = '0;
    case (state_q)
      ENTER_A: begin
        if (inc_pulse && adv_pulse) a_d = '0;
        else if (inc_pulse)         a_d = a_q + WIDTH'(1);
      end
      ENTER_B: begin
        if (inc_pulse && adv_pulse) b_d = '0;
        else if (inc_pulse)         b_d = b_q + WIDTH'(1);
      end
      default: ;
    endcase
    case (state_d)
      ENTER_A: preview_d = a_d[PREVIEW_W-1:0];
      ENTER_B: preview_d = b_d[PREVIEW_W-1:0];
      PRESENT: valid_d   = 1'b1;
      default: ;
    endcase
  end

  // Operand and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      preview_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
      preview_q <= preview_d;
    end
  end

  assign operand_a      = a_q;
  assign operand_b      = b_q;
  assign operands_valid = valid_q;
  assign phase          = state_q;
  assign preview        = preview_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a short debounce window.
module tb_operand_entry;

  logic       clk;
  logic       rst_n;
  logic [1:0] buttons;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       operands_valid;
  logic       operands_ready;
  logic [1:0] phase;
  logic [5:0] preview;

  int checks;
  int failures;

  operand_entry #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .buttons        (buttons),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .operands_valid (operands_valid),
    .operands_ready (operands_ready),
    .phase          (phase),
    .preview        (preview)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic v, input logic [1:0] ph, input logic [5:0] pv);
    check({tag, ".a"},       32'(operand_a),      32'(a));
    check({tag, ".b"},       32'(operand_b),      32'(b));
    check({tag, ".valid"},   32'(operands_valid), 32'(v));
    check({tag, ".phase"},   32'(phase),          32'(ph));
    check({tag, ".preview"}, 32'(preview),        32'(pv));
  endtask

  // Hold the selected buttons low for 10 cycles, then release for 10.
  task automatic press(input logic [1:0] mask);
    buttons = ~mask;
    cyc(10);
    buttons = 2'b11;
    cyc(10);
  endtask

  task automatic glitch(input int len);
    buttons[0] = 1'b0;
    cyc(len);
    buttons[0] = 1'b1;
    cyc(10);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    buttons        = 2'b11;
    operands_ready = 1'b0;

    cyc(3);
    check_all("reset", 8'h00, 8'h00, 1'b0, 2'd0, 6'h00);
    rst_n = 1'b1;
    cyc(2);
    check_all("post_reset", 8'h00, 8'h00, 1'b0, 2'd0, 6'h00);

    // Operand entry: 3 incs, advance, 5 incs, advance.
    for (int i = 0; i < 3; i++) press(2'b01);
    check_all("enter_a", 8'h03, 8'h00, 1'b0, 2'd0, 6'h03);
    press(2'b10);
    check_all("to_b", 8'h03, 8'h00, 1'b0, 2'd1, 6'h00);
    for (int i = 0; i < 5; i++) press(2'b01);
    check_all("enter_b", 8'h03, 8'h05, 1'b0, 2'd1, 6'h05);
    press(2'b10);
    check_all("present", 8'h03, 8'h05, 1'b1, 2'd2, 6'h00);

    // Valid holds without ready; presses ignored in PRESENT.
    cyc(20);
    check_all("hold", 8'h03, 8'h05, 1'b1, 2'd2, 6'h00);
    press(2'b01);
    press(2'b10);
    check_all("present_ignore", 8'h03, 8'h05, 1'b1, 2'd2, 6'h00);

    // Handshake: one cycle of ready.
    operands_ready = 1'b1;
    cyc(1);
    operands_ready = 1'b0;
    check_all("handshake", 8'h03, 8'h05, 1'b0, 2'd0, 6'h03);

    // Ready outside PRESENT is ignored.
    operands_ready = 1'b1;
    cyc(3);
    operands_ready = 1'b0;
    cyc(1);
    check_all("ready_in_a", 8'h03, 8'h05, 1'b0, 2'd0, 6'h03);

    // Bounce: 3-cycle glitch ignored, 6-cycle low counts once.
    glitch(3);
    check("glitch3.a", 32'(operand_a), 32'h03);
    glitch(6);
    check("glitch6.a", 32'(operand_a), 32'h04);

    // Latency: pulse after 6 edges, operand visible after the 7th.
    buttons[0] = 1'b0;
    cyc(6);
    check("latency_early.a", 32'(operand_a), 32'h04);
    cyc(1);
    check("latency_on.a", 32'(operand_a), 32'h05);
    cyc(3);
    buttons[0] = 1'b1;
    cyc(10);
    check("latency_once.a", 32'(operand_a), 32'h05);

    // Wrap: bring A to FF, then one more increment.
    for (int i = 0; i < 250; i++) press(2'b01);
    check_all("a_ff", 8'hFF, 8'h05, 1'b0, 2'd0, 6'h3F);
    press(2'b01);
    check_all("a_wrap", 8'h00, 8'h05, 1'b0, 2'd0, 6'h00);

    // Clear: both buttons in ENTER_B.
    press(2'b10);
    check_all("b_edit", 8'h00, 8'h05, 1'b0, 2'd1, 6'h05);
    press(2'b11);
    check_all("b_clear", 8'h00, 8'h00, 1'b0, 2'd1, 6'h00);

    // Reset mid-count in ENTER_B.
    press(2'b01);
    check("pre_rst.b", 32'(operand_b), 32'h01);
    buttons[0] = 1'b0;
    cyc(4);
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 8'h00, 1'b0, 2'd0, 6'h00);
    cyc(2);
    buttons[0] = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    cyc(15);
    check_all("post_mid_rst", 8'h00, 8'h00, 1'b0, 2'd0, 6'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
